// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost-table stage: matrix geometry,
// loader state encoding and the {W,J} flat-index helper.
package jam_pkg;

  localparam int LIST_COUNT  = 8;
  localparam int COST_W      = 7;
  localparam int IDX_W       = 3;
  localparam int COST_SUM_W  = 10;
  localparam int ENTRY_COUNT = LIST_COUNT * LIST_COUNT;
  localparam int FLAT_W      = 2 * IDX_W;

  // Flat index of the last entry in the table.
  localparam logic [FLAT_W-1:0] LAST_IDX = FLAT_W'(ENTRY_COUNT - 1);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Row-major flat index of table[w][j].
  function automatic logic [FLAT_W-1:0] flat_idx(input logic [IDX_W-1:0] w,
                                                 input logic [IDX_W-1:0] j);
    return {w, j};
  endfunction

endpackage

// File: rtl/jam_row_min.sv
// Per-row running minimum and accumulated lower bound (sum of row minima).
// Only instantiated when JAM_ROW_MIN_EN is defined.
module jam_row_min
  import jam_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [COST_W-1:0]     i_entry,
  output logic [COST_W-1:0]     o_row_min,
  output logic [COST_SUM_W-1:0] o_bound
);

  logic [COST_W-1:0]     r_min;
  logic [COST_SUM_W-1:0] r_acc;
  logic [COST_W-1:0]     w_cur_min;

  // Minimum including the entry arriving this cycle; a new row restarts it.
  always_comb begin
    w_cur_min = r_min;
    if (i_first || (i_entry < r_min)) begin
      w_cur_min = i_entry;
    end
  end

  // Track the row minimum and fold it into the bound at each row end.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_min <= '1;
      r_acc <= '0;
    end else if (i_clear) begin
      r_min <= '1;
      r_acc <= '0;
    end else if (i_valid) begin
      r_min <= w_cur_min;
      if (i_last) begin
        // 8 rows of at most 127 sum to 1016, so the add never overflows.
        r_acc <= r_acc + COST_SUM_W'(w_cur_min);
      end
    end
  end

  assign o_row_min = r_min;
  assign o_bound   = r_acc;

endmodule

// File: rtl/jam_cost_table.sv
// Cost-table stage for the job assignment machine: loads an 8x8 cost
// matrix row-major over valid/ready, then serves zero-latency lookups and
// releases the JAM from reset. Optional feature: define JAM_ROW_MIN_EN to
// compute LowerBound (sum of row minima); otherwise LowerBound is 0.
module jam_cost_table
  import jam_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  Reload,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [COST_W-1:0]     InCost,
  input  logic [IDX_W-1:0]      W,
  input  logic [IDX_W-1:0]      J,
  output logic [COST_W-1:0]     Cost,
  output logic                  TableReady,
  output logic                  JamRst,
  output logic [COST_SUM_W-1:0] LowerBound
);

  state_t              r_state;
  logic [FLAT_W-1:0]   r_idx;
  logic                r_table_ready;
  logic [COST_W-1:0]   r_table [ENTRY_COUNT];

  logic                w_in_ready;
  logic                w_xfer;

  // Reload outranks a concurrent entry, so that entry is never written.
  assign w_in_ready = (r_state == ST_LOAD);
  assign w_xfer     = InValid && w_in_ready && !Reload;

  // Loader FSM: count accepted entries, leave LOAD on the 64th.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_LOAD;
      r_idx         <= '0;
      r_table_ready <= 1'b0;
    end else if (Reload) begin
      r_state       <= ST_LOAD;
      r_idx         <= '0;
      r_table_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state       <= ST_READY;
              r_table_ready <= 1'b1;
            end
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // Table storage: written only by accepted transfers.
  // NOTE: the array has no reset; contents are don't-care until a full load
  // completes, and Cost is forced to 0 until then.
  always_ff @(posedge CLK) begin
    if (w_xfer) begin
      r_table[r_idx] <= InCost;
    end
  end

  // Zero-latency lookup: the JAM sums Cost in the same cycle it drives W/J.
  // NOTE: Cost gets a default before the conditional so no latch is inferred.
  always_comb begin
    Cost = '0;
    if (r_table_ready) begin
      Cost = r_table[flat_idx(W, J)];
    end
  end

  assign InReady    = w_in_ready;
  assign TableReady = r_table_ready;
  assign JamRst     = ~r_table_ready;

`ifdef JAM_ROW_MIN_EN
  logic [COST_W-1:0] w_row_min;

  jam_row_min u_row_min (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_clear   (Reload),
    .i_valid   (w_xfer),
    .i_first   (r_idx[IDX_W-1:0] == '0),
    .i_last    (r_idx[IDX_W-1:0] == '1),
    .i_entry   (InCost),
    .o_row_min (w_row_min),
    .o_bound   (LowerBound)
  );
`else
  assign LowerBound = '0;
`endif

endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: stimulus pushes expected observations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_jam_cost_table;
  import jam_pkg::*;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  Reload = 1'b0;
  logic                  InValid = 1'b0;
  logic                  InReady;
  logic [COST_W-1:0]     InCost = '0;
  logic [IDX_W-1:0]      W = '0;
  logic [IDX_W-1:0]      J = '0;
  logic [COST_W-1:0]     Cost;
  logic                  TableReady;
  logic                  JamRst;
  logic [COST_SUM_W-1:0] LowerBound;

  jam_cost_table dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .Reload     (Reload),
    .InValid    (InValid),
    .InReady    (InReady),
    .InCost     (InCost),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .TableReady (TableReady),
    .JamRst     (JamRst),
    .LowerBound (LowerBound)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string                 name;
    logic [IDX_W-1:0]      w;
    logic [IDX_W-1:0]      j;
    logic [COST_W-1:0]     cost;
    logic                  ready;
    logic                  chk_lb;
    logic [COST_SUM_W-1:0] lb;
  } exp_t;

  exp_t              sb_q[$];
  int                checks = 0;
  int                failures = 0;
  logic [COST_W-1:0] model [ENTRY_COUNT];
  logic              model_ready = 1'b0;
  int                model_idx = 0;

`ifdef JAM_ROW_MIN_EN
  localparam logic [COST_SUM_W-1:0] EXP_LB = 10'd68;
`else
  localparam logic [COST_SUM_W-1:0] EXP_LB = 10'd0;
`endif

  // Monitor: one queued expectation is compared per falling edge.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [COST_W-1:0] exp_cost;
      e = sb_q.pop_front();
      exp_cost = e.ready ? e.cost : '0;
      checks++;
      if (W !== e.w || J !== e.j || Cost !== exp_cost || TableReady !== e.ready ||
          JamRst !== ~e.ready || InReady !== ~e.ready ||
          (e.chk_lb && LowerBound !== e.lb)) begin
        failures++;
        $display("FAIL %s: W=%0d J=%0d got Cost=%0d TableReady=%b JamRst=%b InReady=%b LowerBound=%0d, want Cost=%0d TableReady=%b JamRst=%b InReady=%b LowerBound=%0d(chk=%b)",
                 e.name, W, J, Cost, TableReady, JamRst, InReady, LowerBound,
                 exp_cost, e.ready, ~e.ready, ~e.ready, e.lb, e.chk_lb);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Queue the expected observation for the current cycle's W/J.
  task automatic expect_now(input string name, input bit chk_lb = 1'b0,
                            input logic [COST_SUM_W-1:0] lb = '0);
    exp_t e;
    e.name   = name;
    e.w      = W;
    e.j      = J;
    e.cost   = model[flat_idx(W, J)];
    e.ready  = model_ready;
    e.chk_lb = chk_lb;
    e.lb     = lb;
    sb_q.push_back(e);
  endtask

  // One accepted transfer, optionally followed by an idle gap cycle.
  task automatic send(input logic [COST_W-1:0] v, input bit gap);
    InValid = 1'b1;
    InCost  = v;
    model[model_idx] = v;
    tick();
    model_idx++;
    if (model_idx == ENTRY_COUNT) begin
      model_ready = 1'b1;
      model_idx   = 0;
    end
    InValid = 1'b0;
    if (gap) tick();
  endtask

  task automatic do_reload();
    Reload = 1'b1;
    tick();
    Reload = 1'b0;
    model_ready = 1'b0;
    model_idx   = 0;
  endtask

  task automatic dump(input string name);
    logic [FLAT_W-1:0] a;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      a = FLAT_W'(i);
      W = a[FLAT_W-1:IDX_W];
      J = a[IDX_W-1:0];
      expect_now(name);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state, then back-to-back load of k%128.
    W = 3'd3; J = 3'd5;
    expect_now("reset_state", 1'b1, 10'd0);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    for (int k = 0; k < ENTRY_COUNT; k++) begin
      send(COST_W'(k % 128), 1'b0);
      if (k == 62) expect_now("t1_not_ready_after_63");
    end
    W = 3'd3; J = 3'd5;
    expect_now("t1_ready_cost_3_5");
    tick();

    // Reload from READY drops TableReady and zeroes Cost.
    do_reload();
    expect_now("reload_from_ready", 1'b1, 10'd0);
    tick();

    // 2: InValid toggling 1,0,1,0: 64 transfers over 127 cycles.
    for (int k = 0; k < ENTRY_COUNT; k++) begin
      send(COST_W'((k * 3 + 7) % 128), k < ENTRY_COUNT - 1);
      if (k == 62) expect_now("t2_not_ready_before_last");
    end
    dump("t2_table");

    // 3: Reload at idx=40 together with InValid: entry dropped, full reload needed.
    do_reload();
    for (int k = 0; k < 40; k++) send(COST_W'((k * 5 + 1) % 128), 1'b0);
    Reload = 1'b1; InValid = 1'b1; InCost = 7'd99;
    tick();
    Reload = 1'b0; InValid = 1'b0;
    model_idx = 0;
    for (int k = 0; k < ENTRY_COUNT; k++) begin
      send(COST_W'((k * 11 + 2) % 128), 1'b0);
      if (k == 62) expect_now("t3_not_ready_after_63");
    end
    dump("t3_table");

    // 4: RST_N low for one cycle at idx=20; load restarts at entry 0.
    do_reload();
    for (int k = 0; k < 20; k++) send(COST_W'(100 - k), 1'b0);
    RST_N = 1'b0;
    model_idx = 0;
    W = 3'd2; J = 3'd4;
    expect_now("t4_in_reset", 1'b1, 10'd0);
    tick();
    RST_N = 1'b1;
    for (int k = 0; k < ENTRY_COUNT; k++) send(COST_W'((k * 7 + 13) % 128), 1'b0);
    dump("t4_table");

    // 5: InValid held high in READY must not disturb the table.
    InValid = 1'b1; InCost = 7'd127;
    for (int c = 0; c < 10; c++) begin
      W = 3'(c); J = 3'(c + 1);
      expect_now("t5_ready_ignores_valid");
      tick();
    end
    InValid = 1'b0;
    dump("t5_table");

    // 6: row minima: row r = {r+10, 5+r, 90, 40+j...}; bound 68 with the feature.
    do_reload();
    expect_now("t6_lb_cleared", 1'b1, 10'd0);
    for (int r = 0; r < LIST_COUNT; r++) begin
      for (int c = 0; c < LIST_COUNT; c++) begin
        if (c == 0)      send(COST_W'(r + 10), 1'b0);
        else if (c == 1) send(COST_W'(r + 5), 1'b0);
        else if (c == 2) send(7'd90, 1'b0);
        else             send(COST_W'(40 + c), 1'b0);
      end
    end
    W = 3'd4; J = 3'd1;
    expect_now("t6_lower_bound", 1'b1, EXP_LB);
    tick();

    tick(); tick();
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
